hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Pipeline control block that detects hazards and produces the stall and flush controls for the 5-stage pipeline.
- Handles three hazard types: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits.
- Drives `hazard_selector`, the bubble indicator that the forwarding logic consumes to suppress forwarding into a bubbled ID/EX slot.
- Sits in the ID stage next to the forwarding logic and holds a small FSM plus performance counters.

Parameters:
- ADDR_W, 5, register address width.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ID_EX_MemRead  input  1  the instruction in EX is a load.
- ID_EX_Register_Rd  input  ADDR_W  destination register of the instruction in EX.
- IF_ID_Register_Rs1  input  ADDR_W  rs1 of the instruction in ID.
- IF_ID_Register_Rs2  input  ADDR_W  rs2 of the instruction in ID.
- IF_ID_Uses_Rs2  input  1  the ID instruction reads rs2 (R/S/B type).
- branch_taken  input  1  the branch/jump resolved in EX is taken.
- mem_req  input  1  the MEM-stage instruction accesses data memory.
- mem_ready  input  1  data memory completes the access this cycle.
- PC_Write  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register enable.
- IF_ID_Flush  output  1  zero the IF/ID register.
- ID_EX_Flush  output  1  insert a bubble into ID/EX.
- EX_MEM_Stall  output  1  hold EX/MEM and MEM/WB.
- hazard_selector  output  1  ID/EX currently holds a bubble; forwarding must select 00.
- stall_count  output  CNT_W  cycles with PC_Write=0, saturating.
- flush_count  output  CNT_W  branch flushes applied, saturating.

Behaviour:
- Reset is asynchronous and active-high.
  - state=RUN, pending_flush=0, hazard_selector=0, both counters=0.
  - While reset is high: PC_Write=1, IF_ID_Write=1, all flush and stall outputs 0.
- Defaults every cycle: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, EX_MEM_Stall=0.
- load_use = ID_EX_MemRead && ID_EX_Register_Rd!=0 && (Rd==IF_ID_Register_Rs1 || (IF_ID_Uses_Rs2 && Rd==IF_ID_Register_Rs2)).
- State RUN. Conditions are evaluated in priority order, first match wins; control outputs are combinational and take effect in the same cycle.
  1. mem_req && !mem_ready: PC_Write=0, IF_ID_Write=0, EX_MEM_Stall=1. Next state MEM_WAIT; pending_flush<=branch_taken.
  2. branch_taken: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 (branch target loaded). Stay in RUN.
  3. load_use: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Exactly one bubble results, because next cycle the load is in MEM and load_use falls.
- State MEM_WAIT:
  - If !mem_ready: full freeze (PC_Write=0, IF_ID_Write=0, EX_MEM_Stall=1), no flushes. pending_flush |= branch_taken.
  - If mem_ready: stall outputs return to their defaults and the pipeline advances this cycle.
    - If pending_flush || branch_taken: IF_ID_Flush=1, ID_EX_Flush=1.
    - Else if load_use: apply the load-use stall in this same cycle.
    - Then pending_flush<=0 and next state RUN.
- A branch flush overrides load-use in every state; the flush discards the dependent instruction.
- hazard_selector is registered: hazard_selector<=ID_EX_Flush. It reads 1 exactly in the cycle after a bubble is inserted.
- stall_count increments each cycle with PC_Write=0 and sticks at 2^CNT_W-1.
- flush_count increments each cycle with IF_ID_Flush=1 and saturates the same way.
- A mid-operation reset aborts MEM_WAIT immediately and clears pending_flush; no flush is replayed after reset.
- mem_ready asserted in RUN without mem_req is ignored.
- The FSM is 1 bit wide, with no illegal states.

Decomposition:
- The shared pipeline package holds:
  - state encoding (RUN=1'b0, MEM_WAIT=1'b1);
  - ADDR_W;
  - the forward-select constants FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10.
- One natural sub-module, sat_counter: parameter CNT_W, ports clk, reset, inc, count. It is instantiated twice, once per counter.

Test Plan:
- Load-use stall: ID_EX_MemRead=1, ID_EX_Register_Rd=5, IF_ID_Register_Rs1=5.
  - Same cycle: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - Next cycle: hazard_selector=1; stall_count=1.
- Register x0 and unused rs2: Rd=0 matching Rs1=0 gives no stall. Rd=7 matching Rs2=7 with IF_ID_Uses_Rs2=0 gives no stall.
- Branch beats load-use: branch_taken=1 together with a load-use match.
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1.
  - flush_count=1, stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
  - EX_MEM_Stall=1 and PC_Write=0 for 3 cycles, deasserted on the ready cycle.
  - stall_count=3.
- Pending branch: branch_taken pulses in cycle 1 of a 4-cycle memory wait. The flush fires exactly on the mem_ready cycle, and flush_count=1.
- Reset during MEM_WAIT: assert reset asynchronously mid-clock.
  - Outputs return to their defaults immediately; counters=0.
  - After release, a mem_ready pulse produces no flush.
- Saturation: with CNT_W=4, hold a stall for 20 cycles; stall_count stays at 15.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions: FSM encoding, register address width and
// forwarding mux selects used by the hazard unit and the forwarding logic.
package hazard_detection_unit_pkg;

    localparam int ADDR_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_NONE   = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Bundle of pipeline-register observations and hazard controls exchanged
// between the pipeline datapath (master) and the hazard unit (slave).
interface hazard_detection_unit_if #(
    parameter int ADDR_W = hazard_detection_unit_pkg::ADDR_W,
    parameter int CNT_W  = 16
);
    logic              ID_EX_MemRead;
    logic [ADDR_W-1:0] ID_EX_Register_Rd;
    logic [ADDR_W-1:0] IF_ID_Register_Rs1;
    logic [ADDR_W-1:0] IF_ID_Register_Rs2;
    logic              IF_ID_Uses_Rs2;
    logic              branch_taken;
    logic              mem_req;
    logic              mem_ready;
    logic              PC_Write;
    logic              IF_ID_Write;
    logic              IF_ID_Flush;
    logic              ID_EX_Flush;
    logic              EX_MEM_Stall;
    logic              hazard_selector;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output ID_EX_MemRead, ID_EX_Register_Rd, IF_ID_Register_Rs1,
               IF_ID_Register_Rs2, IF_ID_Uses_Rs2, branch_taken, mem_req, mem_ready,
        input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Stall,
               hazard_selector, stall_count, flush_count
    );

    modport slave (
        input  ID_EX_MemRead, ID_EX_Register_Rd, IF_ID_Register_Rs1,
               IF_ID_Register_Rs2, IF_ID_Uses_Rs2, branch_taken, mem_req, mem_ready,
        output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Stall,
               hazard_selector, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard unit: load-use bubbles, taken-branch flushes and
// data-memory wait freezes, with a branch remembered across a memory wait.
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int ADDR_W = hazard_detection_unit_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    hazard_detection_unit_if.slave  hif
);

    state_t            state;
    logic              pending_flush;
    logic              load_use;
    logic [ADDR_W-1:0] rd;
    logic              pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_stall;

    assign rd = hif.ID_EX_Register_Rd;

    // x0 never creates a dependency; rs2 only matters when the ID instruction reads it.
    assign load_use = hif.ID_EX_MemRead && (rd != '0) &&
                      ((rd == hif.IF_ID_Register_Rs1) ||
                       (hif.IF_ID_Uses_Rs2 && (rd == hif.IF_ID_Register_Rs2)));

    // Combinational control decode; a branch flush always wins over load-use.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (hif.mem_req && !hif.mem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        ex_mem_stall = 1'b1;
                    end else if (hif.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!hif.mem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        ex_mem_stall = 1'b1;
                    end else if (pending_flush || hif.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM, deferred-branch flag and registered bubble indicator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RUN;
            pending_flush   <= 1'b0;
            hif.hazard_selector <= 1'b0;
        end else begin
            hif.hazard_selector <= id_ex_flush;
            case (state)
                RUN: begin
                    if (hif.mem_req && !hif.mem_ready) begin
                        state         <= MEM_WAIT;
                        pending_flush <= hif.branch_taken;
                    end
                end
                MEM_WAIT: begin
                    if (!hif.mem_ready) begin
                        pending_flush <= pending_flush | hif.branch_taken;
                    end else begin
                        pending_flush <= 1'b0;
                        state         <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign hif.PC_Write     = pc_write;
    assign hif.IF_ID_Write  = if_id_write;
    assign hif.IF_ID_Flush  = if_id_flush;
    assign hif.ID_EX_Flush  = id_ex_flush;
    assign hif.EX_MEM_Stall = ex_mem_stall;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write),
        .count (hif.stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush),
        .count (hif.flush_count)
    );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: single-cycle vector table in RUN plus hand-written
// memory-wait, pending-branch, async-reset and saturation sequences.
module tb_hazard_detection_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    logic prev_idf = 1'b0;

    always #5 clk = ~clk;

    hazard_detection_unit_if #(.ADDR_W(5), .CNT_W(16)) hif ();
    hazard_detection_unit_if #(.ADDR_W(5), .CNT_W(4))  hif4 ();

    // Narrow-counter instance sees exactly the same pipeline inputs.
    assign hif4.ID_EX_MemRead      = hif.ID_EX_MemRead;
    assign hif4.ID_EX_Register_Rd  = hif.ID_EX_Register_Rd;
    assign hif4.IF_ID_Register_Rs1 = hif.IF_ID_Register_Rs1;
    assign hif4.IF_ID_Register_Rs2 = hif.IF_ID_Register_Rs2;
    assign hif4.IF_ID_Uses_Rs2     = hif.IF_ID_Uses_Rs2;
    assign hif4.branch_taken       = hif.branch_taken;
    assign hif4.mem_req            = hif.mem_req;
    assign hif4.mem_ready          = hif.mem_ready;

    hazard_detection_unit #(.ADDR_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif)
    );

    hazard_detection_unit #(.ADDR_W(5), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .hif   (hif4)
    );

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u2, br, mq, my;
        logic [4:0] exp;   // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Stall}
    } vec_t;

    vec_t v[10];

    function automatic logic [4:0] ctl();
        return {hif.PC_Write, hif.IF_ID_Write, hif.IF_ID_Flush, hif.ID_EX_Flush, hif.EX_MEM_Stall};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u2, input logic br,
                         input logic mq, input logic my);
        hif.ID_EX_MemRead      = mr;
        hif.ID_EX_Register_Rd  = rd;
        hif.IF_ID_Register_Rs1 = rs1;
        hif.IF_ID_Register_Rs2 = rs2;
        hif.IF_ID_Uses_Rs2     = u2;
        hif.branch_taken       = br;
        hif.mem_req            = mq;
        hif.mem_ready          = my;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected-counter model driven from the expected control vector.
    task automatic acct(input logic [4:0] e);
        if (!e[4]) exp_stall++;
        if (e[2])  exp_flush++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000}; // idle
        v[1] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010}; // load-use rs1
        v[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000}; // x0 dest
        v[3] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000}; // rs2 unused
        v[4] = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010}; // rs2 used
        v[5] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11110}; // branch beats load-use
        v[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11000}; // ready w/o req
        v[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11000}; // 1-cycle mem access
        v[8] = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000}; // not a load
        v[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b11110}; // branch alone

        // Reset state: drive a load-use match to prove reset masks controls.
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("reset_ctl", 32'(ctl()), 32'(5'b11000));
        chk("reset_hsel", 32'(hif.hazard_selector), 32'd0);
        chk("reset_stall_cnt", 32'(hif.stall_count), 32'd0);
        chk("reset_flush_cnt", 32'(hif.flush_count), 32'd0);
        idle();
        #2 reset = 1'b0;
        next_cycle();

        // Table of single-cycle RUN-state vectors.
        for (int i = 0; i < 10; i++) begin
            drive(v[i].mr, v[i].rd, v[i].rs1, v[i].rs2, v[i].u2, v[i].br, v[i].mq, v[i].my);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(v[i].exp));
            chk($sformatf("vec%0d_hsel", i), 32'(hif.hazard_selector), 32'(prev_idf));
            chk($sformatf("vec%0d_stall_cnt", i), 32'(hif.stall_count), 32'(exp_stall));
            chk($sformatf("vec%0d_flush_cnt", i), 32'(hif.flush_count), 32'(exp_flush));
            acct(v[i].exp);
            prev_idf = v[i].exp[1];
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("after_table_hsel", 32'(hif.hazard_selector), 32'd1);
        acct(5'b11000);
        next_cycle();

        // Memory wait: three not-ready cycles then ready.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("memwait%0d_ctl", k), 32'(ctl()), 32'(5'b00001));
            acct(5'b00001);
            next_cycle();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("memwait_ready_ctl", 32'(ctl()), 32'(5'b11000));
        acct(5'b11000);
        next_cycle();
        idle();
        @(negedge clk);
        chk("memwait_back_run_ctl", 32'(ctl()), 32'(5'b11000));
        chk("memwait_stall_cnt", 32'(hif.stall_count), 32'(exp_stall));
        acct(5'b11000);
        next_cycle();

        // Branch pulses in cycle 1 of a 4-cycle wait; flush waits for ready.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (k == 1), 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("pend%0d_ctl", k), 32'(ctl()), 32'(5'b00001));
            acct(5'b00001);
            next_cycle();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("pend_ready_ctl", 32'(ctl()), 32'(5'b11110));
        acct(5'b11110);
        next_cycle();
        idle();
        @(negedge clk);
        chk("pend_after_ctl", 32'(ctl()), 32'(5'b11000));
        chk("pend_hsel", 32'(hif.hazard_selector), 32'd1);
        chk("pend_flush_cnt", 32'(hif.flush_count), 32'(exp_flush));
        chk("pend_stall_cnt", 32'(hif.stall_count), 32'(exp_stall));
        acct(5'b11000);
        next_cycle();

        // Async reset in MEM_WAIT with a branch pending.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("prereset_wait_ctl", 32'(ctl()), 32'(5'b00001));
        #2 reset = 1'b1;
        #1;
        chk("midreset_ctl", 32'(ctl()), 32'(5'b11000));
        chk("midreset_stall_cnt", 32'(hif.stall_count), 32'd0);
        chk("midreset_flush_cnt", 32'(hif.flush_count), 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("postreset_ready_ctl", 32'(ctl()), 32'(5'b11000));
        acct(5'b11000);
        next_cycle();
        idle();
        @(negedge clk);
        chk("postreset_flush_cnt", 32'(hif.flush_count), 32'd0);
        chk("postreset_hsel", 32'(hif.hazard_selector), 32'd0);
        acct(5'b11000);
        next_cycle();

        // Saturation: 20 stall cycles against the 4-bit counter instance.
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            acct(5'b00010);
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("sat4_stall_cnt", 32'(hif4.stall_count), 32'd15);
        chk("sat16_stall_cnt", 32'(hif.stall_count), 32'(exp_stall));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard cycle bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
